demux_1_to_4_stream: RTL and testbench
======================================

Name: demux_1_to_4_stream

Overview:
- Registered 1-to-4 stream demultiplexer; the inverse of the team's 4-to-1 data mux.
- Routes each input beat to one of four output channels selected by a 2-bit select, using valid/ready handshakes on both sides.
- Each output channel has one holding register, so a stalled channel does not block beats bound for other channels.
- Sits between a shared producer and four per-lane consumers.

Parameters:
- WIDTH, 32, data width of the input and each output channel.
- SEL_W, 2, select width; fixed at 2. Other values are unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  WIDTH  input payload.
- in_sel  input  SEL_W  destination channel 0..3; sampled with the beat.
- flush  input  1  synchronous clear of all held beats.
- out_valid  output  4  per-channel beat valid; bit i is channel i.
- out_ready  input  4  per-channel consumer ready.
- data_out0  output  WIDTH  channel 0 payload.
- data_out1  output  WIDTH  channel 1 payload.
- data_out2  output  WIDTH  channel 2 payload.
- data_out3  output  WIDTH  channel 3 payload.
- busy  output  1  OR of out_valid.

Behaviour:
- Interface: one clock, clk; reset is rst_n, asynchronous, active-low.
- Reset: out_valid=4'b0000, data_out0..3=0, busy=0. in_ready follows its equation, so it is 1 once flush=0.
- Each channel i is a one-entry slot with state EMPTY (out_valid[i]=0) or FULL (out_valid[i]=1).
- Acceptance: accept = in_valid & in_ready.
  - in_ready = !flush & (!out_valid[in_sel] | out_ready[in_sel]).
  - in_ready is combinational from in_sel, out_valid, out_ready and flush.
- Slot i, priority order each cycle:
  1. flush -> EMPTY; data register unchanged.
  2. accept & in_sel==i -> FULL; data_outi <= in_data. This also covers the drain-and-refill case: with FULL & out_ready[i], the old beat leaves and the new one loads in the same edge.
  3. FULL & out_ready[i] -> EMPTY.
  4. Otherwise hold.
- Latency: accepted beat appears on its channel 1 cycle after the accepting edge.
- Throughput: 1 beat/cycle per channel when that consumer holds out_ready=1.
- Data stability: data_outi changes only on a load into slot i. It is stable while out_valid[i]=1 and out_ready[i]=0.
- Isolation: a FULL, stalled channel deasserts in_ready only for beats whose in_sel addresses it. Beats for other channels proceed.
- Ordering: within one channel, beats leave in acceptance order. No ordering between channels.
- The producer must hold in_data and in_sel stable while in_valid=1 and in_ready=0. The block does not check this.
- No beat duplication; no beat loss except on flush.
- flush asserted together with in_valid: in_ready=0, so no accept. All slots clear, including one that was draining.
- rst_n asserted mid-transfer: all slots empty immediately; pending beats are dropped.

Optional Feature:
- Macro DEMUX_BCAST_EN adds input port bcast (1 bit).
- With the macro and bcast=1:
  - in_sel is ignored.
  - in_ready = !flush & AND over i of (!out_valid[i] | out_ready[i]).
  - On accept, all four slots load in_data and go FULL.
- With the macro and bcast=0: behaviour identical to the base block.
- Without the macro: the bcast port does not exist; unicast only.

Test Plan:
- Reset: rst_n=0 mid-run with out_valid=4'b0101 -> out_valid=0, data_out0..3=0 asynchronously; in_ready=1 once rst_n=1 and flush=0.
- Unicast: in_data=32'hA5A5_0001, in_sel=2, out_ready=4'b1111 -> next cycle out_valid=4'b0100, data_out2=32'hA5A5_0001; following cycle out_valid=0.
- Stall isolation: out_ready=4'b0000; send 32'h11 to ch1, then 32'h22 to ch1, then 32'h33 to ch3.
  - Second beat: in_ready=0.
  - With in_sel=3 presented: in_ready=1.
  - Final state: out_valid=4'b1010, data_out1=32'h11, data_out3=32'h33.
- Back-to-back refill: ch0 FULL with 32'h1, out_ready[0]=1, new beat 32'h2 to ch0 -> accepted same cycle; next cycle out_valid[0]=1, data_out0=32'h2; consumer sees exactly 32'h1 then 32'h2.
- Flush: out_valid=4'b1111 with in_valid=1 and flush=1 -> in_ready=0; next cycle out_valid=0, busy=0; data_out registers unchanged.
- Broadcast (DEMUX_BCAST_EN): bcast=1, in_data=32'hDEAD_BEEF, out_ready=4'b1111 -> out_valid=4'b1111 and all data_out=32'hDEAD_BEEF. Repeat with ch2 FULL and stalled -> in_ready=0 until out_ready[2]=1.

Source files
------------

// File: rtl/demux_1_to_4_stream_if.sv
// Stream bundle for demux_1_to_4_stream: one shared input channel plus four per-lane outputs.
// The master modport is the producer/consumer side; slave is the demux itself.
interface demux_1_to_4_stream_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] data_out0;
    logic [WIDTH-1:0] data_out1;
    logic [WIDTH-1:0] data_out2;
    logic [WIDTH-1:0] data_out3;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, data_out0, data_out1, data_out2, data_out3
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, data_out0, data_out1, data_out2, data_out3
    );
endinterface

// File: rtl/demux_1_to_4_stream.sv
// Registered 1-to-4 stream demux with one holding slot per output lane.
// Define DEMUX_BCAST_EN to add the bcast input, which loads a beat into all four lanes at once.
module demux_1_to_4_stream #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
`ifdef DEMUX_BCAST_EN
    input  logic                 bcast,
`endif
    demux_1_to_4_stream_if.slave bus,
    output logic                 busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e      state_q [4];
    slot_state_e      state_d [4];
    logic [WIDTH-1:0] data_q  [4];

    logic [SEL_W-1:0] sel;
    logic             bcast_sel;
    logic [3:0]       full;
    logic [3:0]       slot_free;
    logic [3:0]       target;
    logic [3:0]       load;
    logic             in_ready;

    assign sel = bus.in_sel;

`ifdef DEMUX_BCAST_EN
    assign bcast_sel = bcast;
`else
    assign bcast_sel = 1'b0;
`endif

    // A beat is accepted only if every slot it targets is empty or draining this edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full[i] = (state_q[i] == FULL);
        end
        slot_free = ~full | bus.out_ready;
        target    = bcast_sel ? 4'b1111 : (4'b0001 << sel);
        in_ready  = !flush && ((target & ~slot_free) == 4'b0000);
        load      = (bus.in_valid && in_ready) ? target : 4'b0000;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            if (flush) begin
                state_d[i] = EMPTY;
            end else if (load[i]) begin
                state_d[i] = FULL;
            end else if (full[i] && bus.out_ready[i]) begin
                state_d[i] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Data only moves on a load, so a stalled lane keeps its payload stable; flush leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    data_q[i] <= bus.in_data;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = full;
    assign bus.data_out0 = data_q[0];
    assign bus.data_out1 = data_q[1];
    assign bus.data_out2 = data_q[2];
    assign bus.data_out3 = data_q[3];
    assign busy          = |full;

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Self-checking bench for demux_1_to_4_stream: directed beats feed per-lane expected queues
// that a negedge monitor drains on every output handshake.
module tb_demux_1_to_4_stream;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;
`ifdef DEMUX_BCAST_EN
    logic bcast;
`endif

    int tests;
    int fails;

    logic [31:0] exp_q [4][$];

    demux_1_to_4_stream_if #(.WIDTH(32), .SEL_W(2)) bus ();

    demux_1_to_4_stream #(.WIDTH(32), .SEL_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
`ifdef DEMUX_BCAST_EN
        .bcast (bcast),
`endif
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] getData(input int i);
        case (i)
            0:       return bus.data_out0;
            1:       return bus.data_out1;
            2:       return bus.data_out2;
            default: return bus.data_out3;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearQueues();
        for (int i = 0; i < 4; i++) exp_q[i].delete();
    endtask

    // Presents one beat for a cycle; the hand-computed in_ready decides whether it is expected downstream.
    task automatic applyStimulus(input logic [31:0] data, input logic [1:0] sel, input logic bc,
                                 input logic exp_ready);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_sel   = sel;
`ifdef DEMUX_BCAST_EN
        bcast = bc;
`endif
        @(negedge clk);
        checkOutput("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
        if (exp_ready) begin
            if (bc) begin
                for (int i = 0; i < 4; i++) exp_q[i].push_back(data);
            end else begin
                exp_q[sel].push_back(data);
            end
        end
        step();
        bus.in_valid = 1'b0;
`ifdef DEMUX_BCAST_EN
        bcast = 1'b0;
`endif
    endtask

    // Monitor: every output handshake must match the oldest expected beat of that lane.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.out_valid[i] && bus.out_ready[i]) begin
                        tests++;
                        if (exp_q[i].size() == 0) begin
                            fails++;
                            $display("[TB] FAIL lane%0d unexpected beat: got %h, expected none", i, getData(i));
                        end else begin
                            logic [31:0] exp_data;
                            exp_data = exp_q[i].pop_front();
                            if (getData(i) !== exp_data) begin
                                fails++;
                                $display("[TB] FAIL lane%0d data: got %h, expected %h", i, getData(i), exp_data);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.out_ready = 4'b0000;
`ifdef DEMUX_BCAST_EN
        bcast = 1'b0;
`endif

        repeat (2) step();
        checkOutput("reset out_valid", {28'b0, bus.out_valid}, 32'h0);
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("reset data_out%0d", i), getData(i), 32'h0);
        rst_n = 1'b1;
        step();
        checkOutput("in_ready after reset", {31'b0, bus.in_ready}, 32'h1);

        $display("[TB] unicast");
        bus.out_ready = 4'b1111;
        applyStimulus(32'hA5A5_0001, 2'd2, 1'b0, 1'b1);
        checkOutput("unicast out_valid", {28'b0, bus.out_valid}, 32'h4);
        checkOutput("unicast data_out2", bus.data_out2, 32'hA5A5_0001);
        step();
        checkOutput("unicast drained", {28'b0, bus.out_valid}, 32'h0);

        $display("[TB] stall isolation");
        bus.out_ready = 4'b0000;
        applyStimulus(32'h11, 2'd1, 1'b0, 1'b1);
        applyStimulus(32'h22, 2'd1, 1'b0, 1'b0);
        applyStimulus(32'h33, 2'd3, 1'b0, 1'b1);
        checkOutput("stall out_valid", {28'b0, bus.out_valid}, 32'hA);
        checkOutput("stall data_out1", bus.data_out1, 32'h11);
        checkOutput("stall data_out3", bus.data_out3, 32'h33);
        checkOutput("stall busy", {31'b0, busy}, 32'h1);
        bus.out_ready = 4'b1111;
        step();
        checkOutput("stall drained", {28'b0, bus.out_valid}, 32'h0);

        $display("[TB] back-to-back refill");
        bus.out_ready = 4'b0000;
        applyStimulus(32'h1, 2'd0, 1'b0, 1'b1);
        bus.out_ready = 4'b0001;
        applyStimulus(32'h2, 2'd0, 1'b0, 1'b1);
        checkOutput("refill out_valid", {28'b0, bus.out_valid}, 32'h1);
        checkOutput("refill data_out0", bus.data_out0, 32'h2);
        step();
        checkOutput("refill drained", {28'b0, bus.out_valid}, 32'h0);

        $display("[TB] flush");
        bus.out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) applyStimulus(32'h100 + i, 2'(i), 1'b0, 1'b1);
        checkOutput("prefill out_valid", {28'b0, bus.out_valid}, 32'hF);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hFFFF_FFFF;
        bus.in_sel   = 2'd0;
        flush        = 1'b1;
        @(negedge clk);
        checkOutput("flush in_ready", {31'b0, bus.in_ready}, 32'h0);
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        clearQueues();
        checkOutput("flush out_valid", {28'b0, bus.out_valid}, 32'h0);
        checkOutput("flush busy", {31'b0, busy}, 32'h0);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("flush data_out%0d kept", i), getData(i), 32'h100 + i);

        $display("[TB] reset mid-run");
        applyStimulus(32'h5, 2'd0, 1'b0, 1'b1);
        applyStimulus(32'h6, 2'd2, 1'b0, 1'b1);
        checkOutput("pre-reset out_valid", {28'b0, bus.out_valid}, 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        clearQueues();
        checkOutput("async reset out_valid", {28'b0, bus.out_valid}, 32'h0);
        checkOutput("async reset data_out0", bus.data_out0, 32'h0);
        checkOutput("async reset data_out2", bus.data_out2, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("in_ready after mid reset", {31'b0, bus.in_ready}, 32'h1);

`ifdef DEMUX_BCAST_EN
        $display("[TB] broadcast");
        bus.out_ready = 4'b1111;
        applyStimulus(32'hDEAD_BEEF, 2'd0, 1'b1, 1'b1);
        checkOutput("bcast out_valid", {28'b0, bus.out_valid}, 32'hF);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("bcast data_out%0d", i), getData(i), 32'hDEAD_BEEF);
        step();
        bus.out_ready = 4'b0000;
        applyStimulus(32'h77, 2'd2, 1'b0, 1'b1);
        bus.out_ready = 4'b1011;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hCAFE_F00D;
        bus.in_sel    = 2'd0;
        bcast         = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("bcast stalled in_ready", {31'b0, bus.in_ready}, 32'h0);
            step();
        end
        bus.out_ready = 4'b1111;
        @(negedge clk);
        checkOutput("bcast released in_ready", {31'b0, bus.in_ready}, 32'h1);
        for (int i = 0; i < 4; i++) exp_q[i].push_back(32'hCAFE_F00D);
        step();
        bus.in_valid = 1'b0;
        bcast        = 1'b0;
        checkOutput("bcast2 out_valid", {28'b0, bus.out_valid}, 32'hF);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("bcast2 data_out%0d", i), getData(i), 32'hCAFE_F00D);
`endif

        bus.out_ready = 4'b1111;
        repeat (3) step();
        for (int i = 0; i < 4; i++) checkOutput($sformatf("lane%0d leftover beats", i), exp_q[i].size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
